// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcodes, ALU encoding, controller states and
// datapath mux selects.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned STATE_W   = 4;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_JALR     = 4'd11,
        ST_LUI      = 4'd12,
        ST_AUIPC    = 4'd13,
        ST_TRAP     = 4'd14
    } ctrl_state_e;

    typedef enum logic [1:0] {SRCA_PC, SRCA_OLD_PC, SRCA_RS1, SRCA_ZERO} src_a_e;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} src_b_e;
    typedef enum logic [1:0] {WB_ALUOUT, WB_MEMDATA, WB_LINK} wb_sel_e;
    typedef enum logic {ADDR_PC, ADDR_ALUOUT} addr_sel_e;
    typedef enum logic {PC_ALU, PC_ALUOUT} pc_sel_e;

    // Which funct3/funct7 interpretation the ALU decoder applies.
    typedef enum logic [1:0] {CLS_R, CLS_I, CLS_BRANCH} alu_cls_e;

endpackage

// File: rtl/rv_alu_decode.sv
// Maps funct3/funct7[5] and instruction class to an ALU operation plus a legality flag.
module rv_alu_decode
    import rv_pkg::*;
(
    input  alu_cls_e    cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    output alu_op_e     alu_op_o,
    output logic        legal_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (cls_i)
            CLS_BRANCH: begin
                case (funct3_i[2:1])
                    2'b00:   alu_op_o = ALU_SUB;
                    2'b10:   alu_op_o = ALU_SLT;
                    2'b11:   alu_op_o = ALU_SLTU;
                    default: legal_o  = 1'b0;
                endcase
            end
            default: begin
                case (funct3_i)
                    3'b000: alu_op_o = (cls_i == CLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op_o = ALU_SLL;
                    3'b010: alu_op_o = ALU_SLT;
                    3'b011: alu_op_o = ALU_SLTU;
                    3'b100: alu_op_o = ALU_XOR;
                    3'b101: alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op_o = ALU_OR;
                    3'b111: alu_op_o = ALU_AND;
                endcase
                // Only SUB and SRA give funct7[5] a meaning in register-register ops.
                if (cls_i == CLS_R && funct7_5_i && funct3_i != 3'b000 && funct3_i != 3'b101) begin
                    legal_o = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and memory port. Only the state and the sticky illegal flag are registered.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN-1:0]     instr,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [XLEN-1:0]     reset_pc,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_ctrl,
    output logic                illegal,
    output logic [STATE_W-1:0]  state_o
);

    ctrl_state_e           state_q, state_d;
    logic                  illegal_q;
    logic [OPCODE_W-1:0]   opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    alu_cls_e              cls;
    alu_op_e               dec_op;
    logic                  dec_legal;
    logic                  br_taken;
    logic                  unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Equal-compare branches invert on funct3[0]; SLT-based ones additionally on funct3[2].
    assign br_taken = zero ^ funct3[0] ^ funct3[2];

    always_comb begin
        cls = CLS_I;
        if (state_q == ST_EXEC_R) begin
            cls = CLS_R;
        end else if (state_q == ST_BRANCH) begin
            cls = CLS_BRANCH;
        end
    end

    rv_alu_decode u_alu_decode (
        .cls_i      (cls),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .alu_op_o   (dec_op),
        .legal_o    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_ALU;
        rf_we        = 1'b0;
        wb_sel       = WB_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_ctrl     = ALU_ADD;
        // Holding reset forces every enable low even though the state already reads FETCH.
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_a = SRCA_OLD_PC;
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_R:                state_d = ST_EXEC_R;
                        OP_I:                state_d = ST_EXEC_I;
                        OP_LOAD, OP_STORE:   state_d = ST_MEM_ADDR;
                        OP_BRANCH:           state_d = ST_BRANCH;
                        OP_JAL:              state_d = ST_JAL;
                        OP_JALR:             state_d = ST_JALR;
                        OP_LUI:              state_d = ST_LUI;
                        OP_AUIPC:            state_d = ST_AUIPC;
                        default:             state_d = ST_TRAP;
                    endcase
                end
                ST_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_ctrl  = dec_op;
                    state_d   = dec_legal ? ST_WB_ALU : ST_TRAP;
                end
                ST_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = dec_op;
                    state_d   = ST_WB_ALU;
                end
                ST_WB_ALU: begin
                    rf_we   = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    state_d   = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = ADDR_ALUOUT;
                    if (mem_ready) begin
                        state_d = ST_WB_MEM;
                    end
                end
                ST_MEM_WR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = ADDR_ALUOUT;
                    if (mem_ready) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_WB_MEM: begin
                    rf_we   = 1'b1;
                    wb_sel  = WB_MEMDATA;
                    state_d = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_ctrl  = dec_op;
                    if (dec_legal) begin
                        if (br_taken) begin
                            pc_we  = 1'b1;
                            pc_sel = PC_ALUOUT;
                        end
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_TRAP;
                    end
                end
                ST_JAL: begin
                    alu_src_a = SRCA_OLD_PC;
                    alu_src_b = SRCB_IMM;
                    rf_we     = 1'b1;
                    wb_sel    = WB_LINK;
                    pc_we     = 1'b1;
                    pc_sel    = PC_ALUOUT;
                    state_d   = ST_FETCH;
                end
                ST_JALR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    rf_we     = 1'b1;
                    wb_sel    = WB_LINK;
                    pc_we     = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    state_d   = ST_WB_ALU;
                end
                ST_AUIPC: begin
                    alu_src_a = SRCA_OLD_PC;
                    alu_src_b = SRCB_IMM;
                    state_d   = ST_WB_ALU;
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_TRAP;
            endcase
        end
    end

    assign reset_pc = RESET_PC;
    assign illegal  = illegal_q;
    assign state_o  = STATE_W'(state_q);

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: per-cycle expected control vectors are
// queued as stimulus is applied and compared against the DUT outputs.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic [31:0] reset_pc;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, illegal;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b;
    logic [3:0]  alu_ctrl, state_o;

    rv_multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .reset_pc     (reset_pc),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_ctrl     (alu_ctrl),
        .illegal      (illegal),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb, a, b, alu, illegal}
    typedef logic [21:0] vec_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        z;
        int          fwait;
        int          n;
        vec_t        seq [4];
    } tvec_t;

    tvec_t tbl [$];
    vec_t  sb_q [$];
    int    n_chk  = 0;
    int    n_pass = 0;

    vec_t V_RST, V_FWAIT, V_FGO, V_DEC, V_WBA, V_MA, V_MRD, V_WBM, V_MWR, V_TRAP;

    function automatic vec_t ev(input logic [3:0] st, input logic [6:0] en, input logic [1:0] wb,
                                input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                                input logic ill);
        return {st, en, wb, a, b, alu, ill};
    endfunction

    function automatic vec_t act();
        return {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we,
                wb_sel, alu_src_a, alu_src_b, alu_ctrl, illegal};
    endfunction

    task automatic check_sb(input string tag);
        vec_t e;
        vec_t a;
        n_chk++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            a = act();
            if (a === e) n_pass++;
            else $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)",
                          tag, a, a[21:18], e, e[21:18]);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic rdy, input logic z, input logic [31:0] ins,
                        input vec_t exp, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        instr     = ins;
        sb_q.push_back(exp);
        #1;
        check_sb(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        sb_q.push_back(V_RST);
        #1;
        check_sb(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input string name, input logic [31:0] ins, input logic z, input int fwait,
                       input int n, input vec_t s0, input vec_t s1, input vec_t s2, input vec_t s3);
        tvec_t t;
        t.name = name; t.ins = ins; t.z = z; t.fwait = fwait; t.n = n;
        t.seq[0] = s0; t.seq[1] = s1; t.seq[2] = s2; t.seq[3] = s3;
        tbl.push_back(t);
    endtask

    task automatic run_trap(input string name, input logic [31:0] ins, input logic has_mid,
                            input vec_t mid);
        do_reset({name, " reset"});
        step(1'b1, 1'b1, ins, V_FGO, {name, " fetch"});
        step(1'b1, 1'b1, ins, V_DEC, {name, " decode"});
        if (has_mid) step(1'b1, 1'b1, ins, mid, {name, " exec"});
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, ins, V_TRAP, $sformatf("%s trap c%0d", name, k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        V_RST   = ev(4'd0,  7'b0000000, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        V_FWAIT = ev(4'd0,  7'b1000000, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0);
        V_FGO   = ev(4'd0,  7'b1001100, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0);
        V_DEC   = ev(4'd1,  7'b0000000, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0);
        V_WBA   = ev(4'd4,  7'b0000001, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        V_MA    = ev(4'd5,  7'b0000000, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0);
        V_MRD   = ev(4'd6,  7'b1010000, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        V_WBM   = ev(4'd8,  7'b0000001, 2'd1, 2'd0, 2'd0, 4'd0, 1'b0);
        V_MWR   = ev(4'd7,  7'b1110000, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        V_TRAP  = ev(4'd14, 7'b0000000, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1);

        add("sub",   32'h40B50533, 1'b0, 2, 3, V_DEC, ev(4'd2, 7'b0, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0), V_WBA, V_RST);
        add("slt",   32'h0020A033, 1'b0, 0, 3, V_DEC, ev(4'd2, 7'b0, 2'd0, 2'd2, 2'd0, 4'd8, 1'b0), V_WBA, V_RST);
        add("addi",  32'h00500093, 1'b0, 0, 3, V_DEC, ev(4'd3, 7'b0, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0), V_WBA, V_RST);
        add("srai",  32'h4010D093, 1'b0, 1, 3, V_DEC, ev(4'd3, 7'b0, 2'd0, 2'd2, 2'd1, 4'd7, 1'b0), V_WBA, V_RST);
        add("lui",   32'h123450B7, 1'b0, 0, 3, V_DEC, ev(4'd12, 7'b0, 2'd0, 2'd3, 2'd1, 4'd0, 1'b0), V_WBA, V_RST);
        add("auipc", 32'h00000097, 1'b0, 0, 3, V_DEC, ev(4'd13, 7'b0, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0), V_WBA, V_RST);
        add("lw",    32'h0042A303, 1'b0, 0, 4, V_DEC, V_MA, V_MRD, V_WBM);
        add("sw",    32'h0062A423, 1'b0, 0, 3, V_DEC, V_MA, V_MWR, V_RST);
        add("beq",   32'h00000063, 1'b1, 0, 2, V_DEC, ev(4'd9, 7'b0000110, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0), V_RST, V_RST);
        add("bne",   32'h00001063, 1'b1, 0, 2, V_DEC, ev(4'd9, 7'b0000000, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0), V_RST, V_RST);
        add("blt",   32'h00004063, 1'b0, 0, 2, V_DEC, ev(4'd9, 7'b0000110, 2'd0, 2'd2, 2'd0, 4'd8, 1'b0), V_RST, V_RST);
        add("bgeu",  32'h00007063, 1'b1, 0, 2, V_DEC, ev(4'd9, 7'b0000110, 2'd0, 2'd2, 2'd0, 4'd9, 1'b0), V_RST, V_RST);
        add("jal",   32'h008000EF, 1'b0, 0, 2, V_DEC, ev(4'd10, 7'b0000111, 2'd2, 2'd1, 2'd1, 4'd0, 1'b0), V_RST, V_RST);
        add("jalr",  32'h000080E7, 1'b0, 0, 2, V_DEC, ev(4'd11, 7'b0000101, 2'd2, 2'd2, 2'd1, 4'd0, 1'b0), V_RST, V_RST);

        do_reset("reset");
        step(1'b0, 1'b0, 32'h0, V_FWAIT, "post-reset fetch");
        check_val("reset_pc", reset_pc, 32'h0000_0000);

        foreach (tbl[i]) begin
            for (int w = 0; w < tbl[i].fwait; w++)
                step(1'b0, tbl[i].z, tbl[i].ins, V_FWAIT, $sformatf("%s fetch-wait%0d", tbl[i].name, w));
            step(1'b1, tbl[i].z, tbl[i].ins, V_FGO, {tbl[i].name, " fetch"});
            for (int k = 0; k < tbl[i].n; k++)
                step(1'b1, tbl[i].z, tbl[i].ins, tbl[i].seq[k], $sformatf("%s c%0d", tbl[i].name, k));
        end
        step(1'b0, 1'b0, 32'h0, V_FWAIT, "return to fetch");

        // Load with two memory wait cycles in MEM_RD.
        step(1'b1, 1'b0, 32'h0042A303, V_FGO, "lw-wait fetch");
        step(1'b1, 1'b0, 32'h0042A303, V_DEC, "lw-wait decode");
        step(1'b1, 1'b0, 32'h0042A303, V_MA,  "lw-wait addr");
        step(1'b0, 1'b0, 32'h0042A303, V_MRD, "lw-wait rd0");
        step(1'b0, 1'b0, 32'h0042A303, V_MRD, "lw-wait rd1");
        step(1'b1, 1'b0, 32'h0042A303, V_MRD, "lw-wait rd2");
        step(1'b1, 1'b0, 32'h0042A303, V_WBM, "lw-wait wb");

        // Reset dropped in the middle of a MEM_RD wait.
        step(1'b1, 1'b0, 32'h0042A303, V_FGO, "lw-rst fetch");
        step(1'b1, 1'b0, 32'h0042A303, V_DEC, "lw-rst decode");
        step(1'b1, 1'b0, 32'h0042A303, V_MA,  "lw-rst addr");
        step(1'b0, 1'b0, 32'h0042A303, V_MRD, "lw-rst rd wait");
        rst_n = 1'b0;
        #1;
        check_val("lw-rst mem_req", {31'd0, mem_req}, 32'd0);
        check_val("lw-rst state",   {28'd0, state_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, V_FWAIT, "after mid-wait reset");

        run_trap("op7f",   32'h0000007F, 1'b0, V_RST);
        run_trap("r-f7",   32'h40007033, 1'b1, ev(4'd2, 7'b0, 2'd0, 2'd2, 2'd0, 4'd2, 1'b0));
        run_trap("br-010", 32'h00002063, 1'b1, ev(4'd9, 7'b0, 2'd0, 2'd2, 2'd0, 4'd0, 1'b0));

        do_reset("reset clears illegal");
        step(1'b0, 1'b0, 32'h0, V_FWAIT, "fetch after trap reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
